// File: rtl/camera_pixel_grabber_if.sv
// rtl/camera_pixel_grabber_if.sv - camera bus, capture control and status bundle
interface camera_pixel_grabber_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 16
);
  logic [DATA_W-1:0] cam_data;
  logic              cam_fval;
  logic              cam_lval;
  logic              cam_valid;
  logic [CNT_W-1:0]  sel_x;
  logic [CNT_W-1:0]  sel_y;
  logic              capture_req;
  logic [DATA_W-1:0] pixel_out;
  logic              capture_done;
  logic              capture_miss;
  logic              busy;
  logic [FCNT_W-1:0] frame_count;

  modport master (
    output cam_data, cam_fval, cam_lval, cam_valid, sel_x, sel_y, capture_req,
    input  pixel_out, capture_done, capture_miss, busy, frame_count
  );

  modport slave (
    input  cam_data, cam_fval, cam_lval, cam_valid, sel_x, sel_y, capture_req,
    output pixel_out, capture_done, capture_miss, busy, frame_count
  );
endinterface

// File: rtl/camera_pixel_grabber.sv
// rtl/camera_pixel_grabber.sv - captures one pixel at a chosen (x,y) of the next full frame
module camera_pixel_grabber #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  camera_pixel_grabber_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_SOF, IN_FRAME} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data, r_pix;
  logic              r_fval, r_lval, r_valid, r_fval_d, r_lval_d;
  logic [CNT_W-1:0]  r_x, r_y, r_lx, r_ly;
  logic              r_hit, r_done, r_miss, r_busy;
  logic [FCNT_W-1:0] r_fcnt;
  logic              w_pix, w_fval_rise, w_fval_fall, w_lval_fall, w_line_end, w_match;
  logic [CNT_W-1:0]  w_y_eff;
  logic              w_busy_nxt, w_done_nxt, w_miss_nxt, w_hit_nxt, w_load, w_latch;

  assign w_pix       = r_valid & r_lval & r_fval;
  assign w_fval_rise = r_fval & ~r_fval_d;
  assign w_fval_fall = ~r_fval & r_fval_d;
  assign w_lval_fall = ~r_lval & r_lval_d;
  assign w_line_end  = w_lval_fall | w_fval_fall;
  // A pixel coinciding with the FVAL rising edge belongs to row 0 even though r_y clears a cycle later.
  assign w_y_eff     = w_fval_rise ? '0 : r_y;
  assign w_match     = w_pix && (r_x == r_lx) && (w_y_eff == r_ly);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_miss_nxt  = r_miss;
    w_hit_nxt   = r_hit;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        // The done cycle already sits in IDLE; a request there is dropped on purpose.
        if (bus.capture_req && !r_done) begin
          w_state_nxt = ARMED;
          w_busy_nxt  = 1'b1;
          w_miss_nxt  = 1'b0;
          w_latch     = 1'b1;
        end
      end
      ARMED: begin
        if (!r_fval) w_state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (w_fval_rise) begin
          w_state_nxt = IN_FRAME;
          w_hit_nxt   = 1'b0;
          if (w_match) begin
            w_load    = 1'b1;
            w_hit_nxt = 1'b1;
          end
        end
      end
      IN_FRAME: begin
        if (w_match && !r_hit) begin
          w_load    = 1'b1;
          w_hit_nxt = 1'b1;
        end
        if (w_fval_fall) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_miss_nxt  = !r_hit;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_fval   <= 1'b0;
      r_lval   <= 1'b0;
      r_valid  <= 1'b0;
      r_fval_d <= 1'b0;
      r_lval_d <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_lx     <= '0;
      r_ly     <= '0;
      r_hit    <= 1'b0;
      r_pix    <= '0;
      r_done   <= 1'b0;
      r_miss   <= 1'b0;
      r_busy   <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_data   <= bus.cam_data;
      r_fval   <= bus.cam_fval;
      r_lval   <= bus.cam_lval;
      r_valid  <= bus.cam_valid;
      r_fval_d <= r_fval;
      r_lval_d <= r_lval;

      if (w_line_end)                 r_x <= '0;
      else if (w_pix && r_x != CNT_MAX) r_x <= r_x + CNT_W'(1);

      if (w_fval_rise)                                   r_y <= '0;
      else if (w_lval_fall && r_fval && r_y != CNT_MAX)  r_y <= r_y + CNT_W'(1);

      if (w_fval_fall) r_fcnt <= r_fcnt + FCNT_W'(1);

      if (w_latch) begin
        r_lx <= bus.sel_x;
        r_ly <= bus.sel_y;
      end
      if (w_load) r_pix <= r_data;
      r_hit  <= w_hit_nxt;
      r_done <= w_done_nxt;
      r_miss <= w_miss_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.pixel_out    = r_pix;
  assign bus.capture_done = r_done;
  assign bus.capture_miss = r_miss;
  assign bus.busy         = r_busy;
  assign bus.frame_count  = r_fcnt;
endmodule

// File: tb/tb_camera_pixel_grabber.sv
// tb/tb_camera_pixel_grabber.sv - scenario bench with a frame-level capture model
module tb_camera_pixel_grabber;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0, n_checks = 0, n_fail = 0;
  int done_cnt = 0, pix_chg_cnt = 0, done_cyc = 0, pix_chg_cyc = 0;
  logic last_miss = 1'b0;
  logic [11:0] prev_pix = 12'd0;
  logic [11:0] m_sx = 0, m_sy = 0, m_data = 0, exp_pix = 0;
  bit m_track = 0, m_found = 0;
  int m_pix_cyc = 0, m_fall_cyc = 0;
  logic [15:0] exp_frames = 0;

  camera_pixel_grabber_if #(.DATA_W(12), .CNT_W(12), .FCNT_W(16)) bus ();
  camera_pixel_grabber #(.DATA_W(12), .CNT_W(12), .FCNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.capture_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      last_miss = bus.capture_miss;
    end
    if (bus.pixel_out !== prev_pix) begin
      pix_chg_cnt++;
      pix_chg_cyc = cyc;
    end
    prev_pix = bus.pixel_out;
  end

  function automatic int sat(int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic drive(bit fv, bit lv, bit vd, logic [11:0] d, bit rq);
    @(negedge clk);
    bus.cam_fval = fv; bus.cam_lval = lv; bus.cam_valid = vd; bus.cam_data = d;
    bus.capture_req = rq;
  endtask

  task automatic arm(logic [11:0] x, logic [11:0] y);
    bus.sel_x = x; bus.sel_y = y; m_sx = x; m_sy = y;
    drive(0, 0, 0, 12'd0, 1);
    drive(0, 0, 0, 12'd0, 0);
  endtask

  // mode 0: 16*row+col, mode 1: random, mode 2: col. rnd adds dropped strobes and stray strobes.
  task automatic send_frame(int lines, int ppl, int mode, bit rnd, int req_line, bit req_at_done);
    int col;
    logic [11:0] d;
    m_found = 0;
    drive(1, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 12'($urandom), 0);
    drive(1, 0, 0, 12'd0, 0);
    for (int l = 0; l < lines; l++) begin
      col = 0;
      while (col < ppl) begin
        if (rnd && $urandom_range(0, 3) == 0) begin
          drive(1, 1, 0, 12'($urandom), 0);
        end else begin
          d = (mode == 0) ? 12'(16 * l + col) : (mode == 1) ? 12'($urandom) : 12'(col);
          drive(1, 1, 1, d, (req_line == l) && (col == 0));
          if (m_track && !m_found && sat(col) == int'(m_sx) && sat(l) == int'(m_sy)) begin
            m_found = 1; m_data = d; m_pix_cyc = cyc;
          end
          col++;
        end
      end
      drive(1, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 12'($urandom), 0);
      drive(1, 0, 0, 12'd0, 0);
    end
    drive(0, 0, 0, 12'd0, 0);
    m_fall_cyc = cyc;
    exp_frames = exp_frames + 16'd1;
    drive(0, 0, 0, 12'd0, 0);
    drive(0, 0, 0, 12'd0, req_at_done);
    drive(0, 0, 0, 12'd0, 0);
    if (m_track && m_found) exp_pix = m_data;
  endtask

  task automatic wait_for_done(int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cam_fval = 0; bus.cam_lval = 0; bus.cam_valid = 0; bus.cam_data = 0;
    bus.capture_req = 0; bus.sel_x = 0; bus.sel_y = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.pixel_out !== 12'd0) begin n_fail++; $display("FAIL reset_pixel_out got %0d want 0", bus.pixel_out); end
    n_checks++; if (bus.capture_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.capture_done); end
    n_checks++; if (bus.capture_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss got %b want 0", bus.capture_miss); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count got %0d want 0", bus.frame_count); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_frames = 0; exp_pix = 0;
  endtask

  task automatic test_basic_hit();
    int d0 = done_cnt;
    m_track = 1;
    arm(12'd5, 12'd2);
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    send_frame(4, 8, 0, 0, -1, 0);
    wait_for_done(d0 + 1);
    n_checks++; if (bus.pixel_out !== 12'd37) begin n_fail++; $display("FAIL basic_pixel got %0d want 37", bus.pixel_out); end
    n_checks++; if (pix_chg_cyc - m_pix_cyc != 2) begin n_fail++; $display("FAIL basic_pixel_latency got %0d want 2", pix_chg_cyc - m_pix_cyc); end
    n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL basic_done_count got %0d want %0d", done_cnt, d0 + 1); end
    n_checks++; if (done_cyc - m_fall_cyc != 2) begin n_fail++; $display("FAIL basic_done_latency got %0d want 2", done_cyc - m_fall_cyc); end
    n_checks++; if (last_miss !== 1'b0) begin n_fail++; $display("FAIL basic_miss got %b want 0", last_miss); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", bus.busy); end
    n_checks++; if (bus.frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_frame_count got %0d want 1", bus.frame_count); end
  endtask

  task automatic test_reset_mid();
    int d0;
    m_track = 0;
    arm(12'd2, 12'd1);
    drive(1, 0, 0, 12'd0, 0);
    for (int c = 0; c < 3; c++) drive(1, 1, 1, 12'(100 + c), 0);
    @(negedge clk);
    reset_n = 1'b0;
    bus.cam_fval = 0; bus.cam_lval = 0; bus.cam_valid = 0;
    #1;
    n_checks++; if (bus.pixel_out !== 12'd0) begin n_fail++; $display("FAIL midrst_pixel got %0d want 0", bus.pixel_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_count got %0d want 0", bus.frame_count); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_frames = 0; exp_pix = 0;
    d0 = done_cnt;
    repeat (10) drive(0, 0, 0, 12'd0, 0);
    #1;
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done got %0d want %0d", done_cnt, d0); end
    m_track = 1;
    arm(12'd1, 12'd0);
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_rearm_busy got %b want 1", bus.busy); end
    send_frame(2, 4, 0, 0, -1, 0);
    wait_for_done(d0 + 1);
    n_checks++; if (bus.pixel_out !== exp_pix) begin n_fail++; $display("FAIL midrst_pixel_after got %0d want %0d", bus.pixel_out, exp_pix); end
  endtask

  task automatic test_mid_frame();
    int d0 = done_cnt;
    bus.sel_x = 0; bus.sel_y = 0; m_sx = 0; m_sy = 0;
    m_track = 0;
    send_frame(3, 6, 0, 0, 1, 0);
    #1;
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL midframe_frameA_done got %0d want %0d", done_cnt, d0); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got %b want 1", bus.busy); end
    m_track = 1;
    send_frame(3, 6, 0, 0, -1, 0);
    wait_for_done(d0 + 1);
    n_checks++; if (bus.pixel_out !== 12'd0) begin n_fail++; $display("FAIL midframe_pixel got %0d want 0", bus.pixel_out); end
    n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL midframe_done_count got %0d want %0d", done_cnt, d0 + 1); end
    n_checks++; if (bus.frame_count !== exp_frames) begin n_fail++; $display("FAIL midframe_frame_count got %0d want %0d", bus.frame_count, exp_frames); end
  endtask

  task automatic test_miss();
    int d0 = done_cnt;
    int c0 = pix_chg_cnt;
    logic [11:0] old = exp_pix;
    m_track = 1;
    arm(12'd10, 12'd1);
    send_frame(4, 8, 0, 0, -1, 0);
    wait_for_done(d0 + 1);
    n_checks++; if (last_miss !== 1'b1) begin n_fail++; $display("FAIL miss_flag got %b want 1", last_miss); end
    n_checks++; if (bus.capture_miss !== 1'b1) begin n_fail++; $display("FAIL miss_flag_held got %b want 1", bus.capture_miss); end
    n_checks++; if (bus.pixel_out !== old || pix_chg_cnt != c0) begin n_fail++; $display("FAIL miss_pixel got %0d want %0d", bus.pixel_out, old); end
  endtask

  task automatic test_busy_reject();
    int d0 = done_cnt;
    m_track = 1;
    arm(12'd3, 12'd2);
    bus.sel_x = 12'd1; bus.sel_y = 12'd1;
    drive(0, 0, 0, 12'd0, 1);
    drive(0, 0, 0, 12'd0, 0);
    #1;
    n_checks++; if (bus.capture_miss !== 1'b0) begin n_fail++; $display("FAIL busy_miss_cleared got %b want 0", bus.capture_miss); end
    send_frame(4, 8, 0, 0, 1, 1);
    wait_for_done(d0 + 1);
    repeat (6) drive(0, 0, 0, 12'd0, 0);
    #1;
    n_checks++; if (bus.pixel_out !== 12'd35) begin n_fail++; $display("FAIL busy_pixel got %0d want 35", bus.pixel_out); end
    n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL busy_done_count got %0d want %0d", done_cnt, d0 + 1); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_req_at_done got %b want 0", bus.busy); end
  endtask

  task automatic test_random();
    int d0;
    for (int it = 0; it < 12; it++) begin
      d0 = done_cnt;
      m_track = 1;
      arm(12'($urandom_range(0, 11)), 12'($urandom_range(0, 6)));
      bus.sel_x = 12'($urandom); bus.sel_y = 12'($urandom);
      send_frame($urandom_range(1, 5), $urandom_range(1, 10), 1, 1, -1, 0);
      wait_for_done(d0 + 1);
      n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want %0d", it, done_cnt, d0 + 1); end
      n_checks++; if (last_miss !== !m_found) begin n_fail++; $display("FAIL rand%0d_miss got %b want %b", it, last_miss, !m_found); end
      n_checks++; if (bus.pixel_out !== exp_pix) begin n_fail++; $display("FAIL rand%0d_pixel got %0d want %0d", it, bus.pixel_out, exp_pix); end
      n_checks++; if (bus.frame_count !== exp_frames) begin n_fail++; $display("FAIL rand%0d_frame_count got %0d want %0d", it, bus.frame_count, exp_frames); end
    end
  endtask

  task automatic test_wrap_sat();
    int d0 = done_cnt;
    int c0;
    logic [11:0] old;
    @(negedge clk);
    force dut.r_fcnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_fcnt;
    #1;
    exp_frames = 16'hFFFF;
    n_checks++; if (bus.frame_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %0d want 65535", bus.frame_count); end
    m_track = 1;
    arm(12'd4095, 12'd0);
    c0 = pix_chg_cnt;
    old = exp_pix;
    send_frame(1, 4100, 2, 0, -1, 0);
    wait_for_done(d0 + 1);
    n_checks++; if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL wrap_frame_count got %0d want 0", bus.frame_count); end
    n_checks++; if (bus.pixel_out !== 12'hFFF) begin n_fail++; $display("FAIL sat_pixel got %0d want 4095", bus.pixel_out); end
    n_checks++; if (pix_chg_cnt != c0 + ((old != 12'hFFF) ? 1 : 0)) begin n_fail++; $display("FAIL sat_single_load got %0d want %0d", pix_chg_cnt - c0, (old != 12'hFFF) ? 1 : 0); end
    n_checks++; if (last_miss !== 1'b0) begin n_fail++; $display("FAIL sat_miss got %b want 0", last_miss); end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_reset_mid();
    test_mid_frame();
    test_miss();
    test_busy_reject();
    test_random();
    test_wrap_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
